// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Grants are gated by a credit count of accepted-but-unread entries, so the FIFO never overflows.
module fifo_wr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  input  logic           rd_en,
  input  logic           fifo_empty,
  output logic [N-1:0]   grant,
  output logic           wt_en,
  output logic [W-1:0]   data_out,
  output logic [CW-1:0]  credit,
  output logic           credit_full
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          wt_en_q, wt_en_d;
  logic [W-1:0]  data_q, data_d;

  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic          avail;
  logic          transfer;
  logic          rd_ok;

  assign avail = credit_q < CW'(DEPTH);
  assign rd_ok = rd_en && !fifo_empty;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = PW'((int'(ptr_q) + k) % int'(N));
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!rst && avail && found) begin
      grant[winner] = 1'b1;
    end
  end

  assign transfer = |grant;

  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    wt_en_d  = transfer;
    data_d   = data_q;
    if (transfer) begin
      data_d = req_data[int'(winner)*W +: W];
      ptr_d  = (int'(winner) == int'(N) - 1) ? '0 : winner + PW'(1);
    end
    if (transfer && !rd_ok) begin
      credit_d = credit_q + CW'(1);
    end else if (!transfer && rd_ok && credit_q != '0) begin
      credit_d = credit_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      credit_q <= '0;
      wt_en_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      wt_en_q  <= wt_en_d;
      data_q   <= data_d;
    end
  end

  assign wt_en       = wt_en_q;
  assign data_out    = data_q;
  assign credit      = credit_q;
  assign credit_full = credit_q == CW'(DEPTH);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a queue-based reference model predicts grants,
// credit and FIFO writes; a negedge monitor scores every write against the expected queue.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           rd_en;
  logic           fifo_empty;
  logic [N-1:0]   grant;
  logic           wt_en;
  logic [W-1:0]   data_out;
  logic [CW-1:0]  credit;
  logic           credit_full;

  fifo_wr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .rd_en      (rd_en),
    .fifo_empty (fifo_empty),
    .grant      (grant),
    .wt_en      (wt_en),
    .data_out   (data_out),
    .credit     (credit),
    .credit_full(credit_full)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int         m_ptr;
  int         m_credit;
  bit         m_pend;
  logic [W-1:0] m_dout;
  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp_q[$];

  // Requester stimulus state
  logic [N-1:0] req_v;
  logic [W-1:0] data_v[N];
  bit           rd_v;
  bit           force_empty;
  bit           hold_mode;
  bit           started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DUT write must match the oldest expected transfer.
  always @(negedge clk) begin
    if (started && wt_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL write_unexpected: got data %0h expected no write", data_out);
      end else begin
        chk("write_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycle(input bit r);
    int   win;
    bit   fe;
    bit   rdok;
    logic [N-1:0] exp_grant;
    @(posedge clk);
    #1;
    if (started) begin
      chk("credit", 32'(credit), 32'(m_credit));
      chk("credit_full", 32'(credit_full), 32'(m_credit == DEPTH));
      chk("wt_en", 32'(wt_en), 32'(m_pend));
      chk("data_out", 32'(data_out), 32'(m_dout));
    end
    fe = (fifo_m.size() == 0) || force_empty;
    rst        = r;
    req        = req_v;
    rd_en      = rd_v;
    fifo_empty = fe;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_v[i];
    #1;
    win = -1;
    if (!r && m_credit < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req_v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_grant = '0;
    if (win >= 0) exp_grant[win] = 1'b1;
    chk("grant", 32'(grant), 32'(exp_grant));

    rdok = rd_v && !fe;
    if (r) begin
      m_ptr = 0; m_credit = 0; m_pend = 1'b0; m_dout = '0;
      fifo_m.delete();
    end else begin
      if (rdok) void'(fifo_m.pop_front());
      if (m_pend) fifo_m.push_back(m_dout);
      m_pend = (win >= 0);
      if (win >= 0) begin
        m_dout = data_v[win];
        exp_q.push_back(data_v[win]);
        m_credit++;
        m_ptr = (win + 1) % N;
      end
      if (rdok && m_credit > 0) m_credit--;
      if (!hold_mode) begin
        if (win >= 0) begin
          if ($urandom_range(1, 0) == 0) req_v[win] = 1'b0;
          else data_v[win] = W'($urandom);
        end
        for (int i = 0; i < N; i++) begin
          if (i != win && !req_v[i] && $urandom_range(2, 0) == 0) begin
            req_v[i]  = 1'b1;
            data_v[i] = W'($urandom);
          end
        end
      end
    end
    started = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; rd_en = 1'b0; fifo_empty = 1'b1;
    rd_v = 1'b0; force_empty = 1'b0; hold_mode = 1'b1;
    m_ptr = 0; m_credit = 0; m_pend = 1'b0; m_dout = '0;

    // Reset with all requesting, then round-robin over 4'hA..4'hD
    req_v = 4'b1111;
    for (int i = 0; i < N; i++) data_v[i] = W'(4'hA + i);
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);

    // Skip idle requesters from ptr=1
    cycle(1'b1);
    req_v = 4'b0001;
    cycle(1'b0);
    req_v = 4'b1001;
    cycle(1'b0);
    cycle(1'b0);

    // Fill to DEPTH with a sole requester and no reads
    cycle(1'b1);
    req_v = 4'b0100;
    data_v[2] = 4'h5;
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0);
    chk("full_credit", 32'(credit), 32'(DEPTH));
    chk("full_flag", 32'(credit_full), 32'd1);
    chk("full_no_grant", 32'(grant), 32'd0);
    rd_v = 1'b1;
    cycle(1'b0);              // read only: 16 -> 15
    cycle(1'b0);              // write and read together: stays 15
    force_empty = 1'b1;
    cycle(1'b0);              // read while empty is ignored
    force_empty = 1'b0;
    rd_v = 1'b0;

    // Randomized traffic with a reset in the middle
    cycle(1'b1);
    hold_mode = 1'b0;
    req_v = '0;
    for (int i = 0; i < 400; i++) begin
      rd_v        = ($urandom_range(2, 0) == 0);
      force_empty = ($urandom_range(7, 0) == 0);
      cycle(i == 200);
    end

    // Drain: nothing new requested, every expected write must have appeared
    hold_mode = 1'b1;
    req_v = '0;
    rd_v = 1'b0;
    force_empty = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
